pulse_period_checker: RTL
=========================

Name: pulse_period_checker

Overview:
- Synthesizable receive-side monitor for a periodic single-cycle pulse stream, such as a counter-based strobe generator that pulses once every PERIOD cycles.
- Measures the interval between pulses and flags early, late and over-wide pulses.
- Declares lock after LOCK_CNT consecutive good periods.
- Sits beside the generator in the temporal examples as the in-silicon counterpart of the bench-level next/never assertions.

Parameters:
CNT_W, 8, width of gap counter and period_meas; saturating
PERIOD, 9, expected cycles between pulse rising cycles; legal range 2..2^CNT_W-2
LOCK_CNT, 3, consecutive good periods required to assert locked; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
enable  input  1  checker enable; low forces IDLE
pulse_in  input  1  monitored pulse, synchronous to clk
clr_err  input  1  clears err_sticky
locked  output  1  LOCK_CNT consecutive good periods seen, no error since
err_early  output  1  one-cycle flag: pulse arrived with gap < PERIOD
err_late  output  1  one-cycle flag: gap exceeded PERIOD with no pulse
err_width  output  1  one-cycle flag: pulse_in high two consecutive cycles
err_sticky  output  1  OR of all error flags since last clr_err
period_meas  output  CNT_W  last measured gap at a pulse

Behaviour:
Reset (rstn low):
- Asynchronous reset; all outputs 0, state IDLE, gap 0, good count 0, pulse_d 0.

States and transitions:
- IDLE: entered whenever enable is low, regardless of state. Gap, good count, locked and the one-cycle error flags are cleared. err_sticky and period_meas hold.
- IDLE -> WAIT_FIRST: enable high.
- WAIT_FIRST -> MEASURE: first cycle with pulse_in=1. Sets gap to 1 on the next cycle. No check on this pulse.

Gap counting in MEASURE and LOCKED:
- gap increments each cycle with pulse_in=0 and saturates at 2^CNT_W-1.
- On a cycle with pulse_in=1, gap is sampled, then reset to 1 on the next cycle.
- Example: pulses at t and t+PERIOD give a sample of exactly PERIOD.
- Every sample loads period_meas.

Pulse classification, applied on a pulse cycle, first match wins:
- width: pulse_d=1, i.e. pulse_in was also high the previous cycle. Raise err_width. State -> MEASURE, good count 0. This also covers gap=1, so err_early does not fire in the same cycle.
- early: gap < PERIOD. Raise err_early. State -> MEASURE, good count 0. The pulse becomes the new reference.
- good: gap == PERIOD. good count increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, state -> LOCKED.

Late detection:
- When gap would reach PERIOD+1 with pulse_in=0, raise err_late once. State -> WAIT_FIRST, good count 0.
- A pulse exactly at gap PERIOD is good, not late.

Timing and priority:
- All error outputs are registered and high for exactly one cycle, the cycle after the offending event.
- locked is registered. It rises the cycle after the LOCK_CNT-th good pulse and falls the cycle after any error.
- err_sticky sets on any error flag. clr_err clears it; if clr_err and a new error coincide, the set wins.
- enable falling mid-period aborts immediately with no error flagged.
- An enable rising edge coinciding with pulse_in does not count that pulse; WAIT_FIRST is entered first.

Test Plan:
- Generator at PERIOD=9 (pulses at t, t+9, t+18, t+27) -> period_meas=9 after each, locked=1 at t+28, no error flags ever.
- Locked stream, one pulse arriving at gap 6 -> err_early high one cycle, period_meas=6, locked drops next cycle, relocks after 3 further 9-cycle gaps.
- Locked stream, pulse missing -> err_late high exactly at cycle t+10 after last pulse, state WAIT_FIRST, next pulse not checked, lock reacquired after 3 good gaps.
- pulse_in held high 2 cycles in a locked stream -> err_width only (err_early stays 0), locked drops, err_sticky=1 until clr_err pulse, then 0.
- err_late coinciding with clr_err -> err_sticky remains 1; enable dropped mid-period -> locked=0 next cycle, no error flag, period_meas retained.
- rstn asserted mid-lock (asynchronous, between clock edges) -> all outputs 0 immediately; after release plus 4 good pulses, locked=1.

Source files
------------

// File: rtl/pulse_period_checker_if.sv
// Signal bundle between a pulse_period_checker and whatever drives and observes it.
// The master modport drives the pulse stream and controls; the slave modport is the checker side.
interface pulse_period_checker_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             pulse_in;
  logic             clr_err;
  logic             locked;
  logic             err_early;
  logic             err_late;
  logic             err_width;
  logic             err_sticky;
  logic [CNT_W-1:0] period_meas;

  modport master (
    output enable, pulse_in, clr_err,
    input  locked, err_early, err_late, err_width, err_sticky, period_meas
  );

  modport slave (
    input  enable, pulse_in, clr_err,
    output locked, err_early, err_late, err_width, err_sticky, period_meas
  );
endinterface

// File: rtl/pulse_period_checker.sv
// Monitors a single-cycle periodic pulse stream: measures the gap between pulses,
// flags early, late and over-wide pulses, and declares lock after LOCK_CNT good periods.
//
// state      | meaning
// IDLE       | disabled; gap, good count and lock cleared
// WAIT_FIRST | waiting for a reference pulse, which is not checked
// MEASURE    | counting the gap and classifying each pulse, not yet locked
// LOCKED     | LOCK_CNT consecutive good periods seen
module pulse_period_checker #(
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 9,
  parameter int LOCK_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  pulse_period_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] PER     = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] GAP_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] gap, gap_nxt;
  logic [3:0]       good, good_nxt;
  logic [CNT_W-1:0] meas, meas_nxt;
  logic             pulse_d;
  logic             early_nxt, late_nxt, width_nxt;
  logic             locked_q, early_q, late_q, width_q, sticky_q;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    good_nxt  = good;
    meas_nxt  = meas;
    early_nxt = 1'b0;
    late_nxt  = 1'b0;
    width_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) state_nxt = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (bus.pulse_in) begin
          state_nxt = MEASURE;
          gap_nxt   = CNT_W'(1);
        end
      end
      MEASURE, LOCKED: begin
        if (bus.pulse_in) begin
          meas_nxt = gap;
          gap_nxt  = CNT_W'(1);
          if (pulse_d) begin
            width_nxt = 1'b1;
            state_nxt = MEASURE;
            good_nxt  = '0;
          end else if (gap < PER) begin
            early_nxt = 1'b1;
            state_nxt = MEASURE;
            good_nxt  = '0;
          end else if (good >= LOCK_N - 4'd1) begin
            good_nxt  = LOCK_N;
            state_nxt = LOCKED;
          end else begin
            good_nxt  = good + 4'd1;
          end
        end else if (gap == PER) begin
          // the gap has run one past PERIOD with no pulse: late, re-acquire reference
          late_nxt  = 1'b1;
          state_nxt = WAIT_FIRST;
          good_nxt  = '0;
          gap_nxt   = '0;
        end else if (gap != GAP_MAX) begin
          gap_nxt = gap + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!bus.enable) begin
      state_nxt = IDLE;
      gap_nxt   = '0;
      good_nxt  = '0;
      early_nxt = 1'b0;
      late_nxt  = 1'b0;
      width_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gap      <= '0;
      good     <= '0;
      meas     <= '0;
      pulse_d  <= 1'b0;
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      width_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      gap      <= gap_nxt;
      good     <= good_nxt;
      meas     <= meas_nxt;
      pulse_d  <= bus.pulse_in;
      locked_q <= (state_nxt == LOCKED);
      early_q  <= early_nxt;
      late_q   <= late_nxt;
      width_q  <= width_nxt;
      // set beats clear whether clr_err lines up with the event or with its flag
      sticky_q <= early_nxt | late_nxt | width_nxt | early_q | late_q | width_q
                  | (sticky_q & ~bus.clr_err);
    end
  end

  assign bus.locked      = locked_q;
  assign bus.err_early   = early_q;
  assign bus.err_late    = late_q;
  assign bus.err_width   = width_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.period_meas = meas;

endmodule
